// File: rtl/arbitro_memoria_pkg.sv
// Shared types and helpers for the two-requester memory-port arbiter.
package arbitro_memoria_pkg;

    // Default geometry of the external memory port and watchdog.
    localparam int ANCHO_DATOS_DEF = 64;
    localparam int ANCHO_DIR_DEF   = 18;
    localparam int MAX_ESPERA_DEF  = 1023;
    localparam int ANCHO_CONT      = 10;

    // Sequencer states: idle, command outstanding, one-cycle completion.
    typedef enum logic [1:0] {
        LIBRE  = 2'd0,
        ESPERA = 2'd1,
        FIN    = 2'd2
    } estado_t;

    // Operation latched at grant time.
    typedef enum logic {
        OP_LEER     = 1'b0,
        OP_ESCRIBIR = 1'b1
    } op_t;

    // Round-robin pick between two requesters: on a tie the one not served
    // last wins, otherwise whoever is asking.
    function automatic logic elegir_rr(input logic req_0,
                                       input logic req_1,
                                       input logic ultimo);
        if (req_0 && req_1) begin
            return ~ultimo;
        end else if (req_1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter and sequencer for the shared external memory port.
// Two engines issue level read/write requests; one command at a time is driven
// with the leer/escribir/operacion_completada handshake, guarded by a watchdog.
module arbitro_memoria
    import arbitro_memoria_pkg::*;
#(
    parameter int ANCHO_DATOS = ANCHO_DATOS_DEF,
    parameter int ANCHO_DIR   = ANCHO_DIR_DEF,
    parameter int MAX_ESPERA  = MAX_ESPERA_DEF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   sol_leer_0_i,
    input  logic                   sol_escribir_0_i,
    input  logic [ANCHO_DIR-1:0]   sol_direccion_0_i,
    input  logic [ANCHO_DATOS-1:0] sol_datos_0_i,
    input  logic                   sol_leer_1_i,
    input  logic                   sol_escribir_1_i,
    input  logic [ANCHO_DIR-1:0]   sol_direccion_1_i,
    input  logic [ANCHO_DATOS-1:0] sol_datos_1_i,
    output logic                   hecho_0_o,
    output logic                   hecho_1_o,
    output logic [ANCHO_DATOS-1:0] datos_salida_o,
    output logic                   error_tiempo_o,
    output logic                   leer_o,
    output logic                   escribir_o,
    output logic [ANCHO_DIR-1:0]   direccion_memoria_o,
    output logic [ANCHO_DATOS-1:0] datos_por_escribir_o,
    input  logic                   operacion_completada_i,
    input  logic [ANCHO_DATOS-1:0] datos_leidos_i
);

    localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(MAX_ESPERA);

    estado_t                estado_q;
    op_t                    op_q;
    logic                   g_q;
    logic                   ultimo_q;
    logic [ANCHO_CONT-1:0]  cnt_q;
    logic [ANCHO_CONT-1:0]  cnt_d;
    logic                   leer_q;
    logic                   escribir_q;
    logic [ANCHO_DIR-1:0]   dir_q;
    logic [ANCHO_DATOS-1:0] datos_wr_q;
    logic [ANCHO_DATOS-1:0] datos_salida_q;
    logic                   hecho_0_q;
    logic                   hecho_1_q;
    logic                   error_q;

    logic                   req_0;
    logic                   req_1;
    logic                   gnt_d;
    op_t                    op_d;
    logic [ANCHO_DIR-1:0]   dir_d;
    logic [ANCHO_DATOS-1:0] datos_d;
    logic                   limite_alcanzado;

    // Grant candidate and the command it would issue; write beats read when
    // a requester raises both.
    always_comb begin
        req_0   = sol_leer_0_i | sol_escribir_0_i;
        req_1   = sol_leer_1_i | sol_escribir_1_i;
        gnt_d   = elegir_rr(req_0, req_1, ultimo_q);
        op_d    = OP_LEER;
        dir_d   = sol_direccion_0_i;
        datos_d = sol_datos_0_i;
        if (gnt_d) begin
            if (sol_escribir_1_i) begin
                op_d = OP_ESCRIBIR;
            end
            dir_d   = sol_direccion_1_i;
            datos_d = sol_datos_1_i;
        end else begin
            if (sol_escribir_0_i) begin
                op_d = OP_ESCRIBIR;
            end
        end
        cnt_d            = cnt_q + 1'b1;
        limite_alcanzado = (MAX_ESPERA != 0) && (cnt_d == LIMITE);
    end

    // Sequencer FSM with all memory-side and requester-side outputs registered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q       <= LIBRE;
            op_q           <= OP_LEER;
            g_q            <= 1'b0;
            ultimo_q       <= 1'b1;
            cnt_q          <= '0;
            leer_q         <= 1'b0;
            escribir_q     <= 1'b0;
            dir_q          <= '0;
            datos_wr_q     <= '0;
            datos_salida_q <= '0;
            hecho_0_q      <= 1'b0;
            hecho_1_q      <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            hecho_0_q <= 1'b0;
            hecho_1_q <= 1'b0;
            case (estado_q)
                LIBRE: begin
                    if (req_0 || req_1) begin
                        g_q        <= gnt_d;
                        op_q       <= op_d;
                        dir_q      <= dir_d;
                        datos_wr_q <= datos_d;
                        leer_q     <= (op_d == OP_LEER);
                        escribir_q <= (op_d == OP_ESCRIBIR);
                        cnt_q      <= '0;
                        estado_q   <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (operacion_completada_i) begin
                        leer_q     <= 1'b0;
                        escribir_q <= 1'b0;
                        if (op_q == OP_LEER) begin
                            datos_salida_q <= datos_leidos_i;
                        end
                        hecho_0_q  <= ~g_q;
                        hecho_1_q  <= g_q;
                        estado_q   <= FIN;
                    end else if (limite_alcanzado) begin
                        leer_q     <= 1'b0;
                        escribir_q <= 1'b0;
                        error_q    <= 1'b1;
                        hecho_0_q  <= ~g_q;
                        hecho_1_q  <= g_q;
                        estado_q   <= FIN;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                FIN: begin
                    ultimo_q <= g_q;
                    estado_q <= LIBRE;
                end
                default: begin
                    estado_q <= LIBRE;
                end
            endcase
        end
    end

    assign hecho_0_o            = hecho_0_q;
    assign hecho_1_o            = hecho_1_q;
    assign datos_salida_o       = datos_salida_q;
    assign error_tiempo_o       = error_q;
    assign leer_o               = leer_q;
    assign escribir_o           = escribir_q;
    assign direccion_memoria_o  = dir_q;
    assign datos_por_escribir_o = datos_wr_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a short watchdog (MAX_ESPERA=8).
module tb_arbitro_memoria;

    localparam int AD = 64;
    localparam int AA = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_l0, s_e0, s_l1, s_e1;
    logic [AA-1:0] dir0, dir1;
    logic [AD-1:0] dat0, dat1;
    logic          hecho_0, hecho_1;
    logic [AD-1:0] datos_salida;
    logic          error_tiempo;
    logic          leer, escribir;
    logic [AA-1:0] direccion_memoria;
    logic [AD-1:0] datos_por_escribir;
    logic          op_comp;
    logic [AD-1:0] dleidos;

    int comparados = 0;
    int fallos     = 0;
    int n;

    arbitro_memoria #(
        .ANCHO_DATOS(AD),
        .ANCHO_DIR  (AA),
        .MAX_ESPERA (8)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .sol_leer_0_i          (s_l0),
        .sol_escribir_0_i      (s_e0),
        .sol_direccion_0_i     (dir0),
        .sol_datos_0_i         (dat0),
        .sol_leer_1_i          (s_l1),
        .sol_escribir_1_i      (s_e1),
        .sol_direccion_1_i     (dir1),
        .sol_datos_1_i         (dat1),
        .hecho_0_o             (hecho_0),
        .hecho_1_o             (hecho_1),
        .datos_salida_o        (datos_salida),
        .error_tiempo_o        (error_tiempo),
        .leer_o                (leer),
        .escribir_o            (escribir),
        .direccion_memoria_o   (direccion_memoria),
        .datos_por_escribir_o  (datos_por_escribir),
        .operacion_completada_i(op_comp),
        .datos_leidos_i        (dleidos)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 time unit past it.
    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        comparados++;
        assert (obs === exp) else begin
            fallos++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        s_l0 = 0; s_e0 = 0; s_l1 = 0; s_e1 = 0;
        dir0 = '0; dir1 = '0; dat0 = '0; dat1 = '0;
        op_comp = 0; dleidos = '0;

        // Reset state
        ciclo(); ciclo();
        chk("rst_leer",      64'(leer), 64'd0);
        chk("rst_escribir",  64'(escribir), 64'd0);
        chk("rst_hecho",     64'({hecho_1, hecho_0}), 64'd0);
        chk("rst_datos_sal", datos_salida, 64'd0);
        chk("rst_error",     64'(error_tiempo), 64'd0);
        chk("rst_dir",       64'(direccion_memoria), 64'd0);
        reset = 1'b0;
        ciclo();

        // Single read by requester 0, completion in the fifth command cycle
        s_l0 = 1; dir0 = 18'h00010;
        ciclo();
        chk("rd_leer_on",    64'(leer), 64'd1);
        chk("rd_escr_off",   64'(escribir), 64'd0);
        chk("rd_dir",        64'(direccion_memoria), 64'h10);
        n = 1;
        for (int i = 0; i < 4; i++) begin
            ciclo();
            if (leer) n++;
        end
        op_comp = 1; dleidos = 64'd7;
        ciclo();
        op_comp = 0; dleidos = '0; s_l0 = 0;
        chk("rd_leer_cycles", 64'(n), 64'd5);
        chk("rd_leer_drop",  64'(leer), 64'd0);
        chk("rd_hecho0",     64'({hecho_1, hecho_0}), 64'b01);
        chk("rd_datos",      datos_salida, 64'd7);
        ciclo();
        chk("rd_hecho_pulse", 64'({hecho_1, hecho_0}), 64'd0);
        chk("rd_error",      64'(error_tiempo), 64'd0);

        // Tie after reset: requester 0 first, then requester 1 write
        reset = 1; ciclo(); reset = 0;
        s_l0 = 1; dir0 = 18'h00100;
        s_e1 = 1; dir1 = 18'h3FFFF; dat1 = 64'hDEADBEEF_00000001;
        ciclo();
        chk("tie_first_leer", 64'(leer), 64'd1);
        chk("tie_first_dir", 64'(direccion_memoria), 64'h100);
        op_comp = 1; dleidos = 64'hA5;
        ciclo();
        op_comp = 0; s_l0 = 0;
        chk("tie_hecho0",    64'({hecho_1, hecho_0}), 64'b01);
        ciclo();
        chk("tie_fin_idle",  64'({leer, escribir}), 64'd0);
        ciclo();
        chk("tie_second_wr", 64'({leer, escribir}), 64'b01);
        chk("tie_second_dir", 64'(direccion_memoria), 64'h3FFFF);
        chk("tie_second_dat", datos_por_escribir, 64'hDEADBEEF_00000001);
        op_comp = 1; dleidos = 64'hFFFF;
        ciclo();
        op_comp = 0; s_e1 = 0;
        chk("tie_hecho1",    64'({hecho_1, hecho_0}), 64'b10);
        chk("tie_wr_nodata", datos_salida, 64'hA5);
        ciclo();
        s_l0 = 1; dir0 = 18'h00200; s_e1 = 1;
        ciclo();
        chk("tie_again_r0",  64'({leer, escribir}), 64'b10);
        chk("tie_again_dir", 64'(direccion_memoria), 64'h200);
        op_comp = 1; dleidos = 64'h1234;
        ciclo();
        op_comp = 0; s_l0 = 0; s_e1 = 0;
        chk("tie_again_h0",  64'({hecho_1, hecho_0}), 64'b01);
        ciclo();

        // Requester 1 asserts read and write together: write wins
        s_l1 = 1; s_e1 = 1; dir1 = 18'h00055; dat1 = 64'h77;
        ciclo();
        chk("rw_cmd_a",      64'({leer, escribir}), 64'b01);
        ciclo();
        chk("rw_cmd_b",      64'({leer, escribir}), 64'b01);
        chk("rw_dat",        datos_por_escribir, 64'h77);
        op_comp = 1; dleidos = 64'h9999;
        ciclo();
        op_comp = 0; s_l1 = 0; s_e1 = 0;
        chk("rw_hecho1",     64'({hecho_1, hecho_0}), 64'b10);
        chk("rw_cmd_drop",   64'({leer, escribir}), 64'd0);
        chk("rw_nodata",     datos_salida, 64'h1234);
        ciclo();

        // Timeout: no completion, command held for 8 cycles
        s_l0 = 1; dir0 = 18'h00ABC;
        ciclo();
        n = 1;
        while (leer && n < 20) begin
            ciclo();
            if (leer) n++;
        end
        s_l0 = 0;
        chk("to_cycles",     64'(n), 64'd8);
        chk("to_hecho0",     64'({hecho_1, hecho_0}), 64'b01);
        chk("to_error",      64'(error_tiempo), 64'd1);
        chk("to_nodata",     datos_salida, 64'h1234);
        ciclo();
        s_e1 = 1; dir1 = 18'h00001; dat1 = 64'h5;
        ciclo();
        op_comp = 1;
        ciclo();
        op_comp = 0; s_e1 = 0;
        chk("to_ok_hecho1",  64'({hecho_1, hecho_0}), 64'b10);
        chk("to_sticky",     64'(error_tiempo), 64'd1);
        ciclo();

        // Completion on the same edge the limit is reached
        reset = 1; ciclo(); reset = 0;
        chk("sim_err_clr",   64'(error_tiempo), 64'd0);
        s_l0 = 1; dir0 = 18'h00321;
        ciclo();
        for (int i = 0; i < 7; i++) ciclo();
        chk("sim_still_cmd", 64'(leer), 64'd1);
        op_comp = 1; dleidos = 64'hCAFE;
        ciclo();
        op_comp = 0; dleidos = '0; s_l0 = 0;
        chk("sim_hecho0",    64'({hecho_1, hecho_0}), 64'b01);
        chk("sim_no_error",  64'(error_tiempo), 64'd0);
        chk("sim_datos",     datos_salida, 64'hCAFE);
        ciclo();

        // Asynchronous reset in the middle of ESPERA
        s_e0 = 1; dir0 = 18'h00777; dat0 = 64'h99;
        ciclo();
        chk("ar_cmd",        64'(escribir), 64'd1);
        ciclo();
        #2 reset = 1;
        #1;
        chk("ar_cmd_off",    64'({leer, escribir}), 64'd0);
        chk("ar_dir_zero",   64'(direccion_memoria), 64'd0);
        chk("ar_wdat_zero",  datos_por_escribir, 64'd0);
        chk("ar_datos_zero", datos_salida, 64'd0);
        s_e0 = 0;
        ciclo();
        reset = 0;
        op_comp = 1; dleidos = 64'hBAD;
        ciclo();
        op_comp = 0; dleidos = '0;
        chk("ar_late_nohecho", 64'({hecho_1, hecho_0}), 64'd0);
        ciclo();
        chk("ar_late_idle",  64'({hecho_1, hecho_0, leer, escribir}), 64'd0);
        chk("ar_late_nodata", datos_salida, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Two-requester arbiter and sequencer for the shared external memory port (64-bit data, 18-bit word address) used by the filter datapath. It accepts read/write requests from two engines, for example the input-sample reader and the result write-back engine. It grants the port round-robin and drives the memory interface with the same leer/escribir/operacion_completada handshake used by the memory test FSMs. It also returns read data and a per-requester completion pulse, and runs a watchdog so a hung memory cannot stall either engine forever.

## Interface
- ANCHO_DATOS, 64, data width.
- ANCHO_DIR, 18, word-address width.
- MAX_ESPERA, 1023, maximum cycles spent in ESPERA before a timeout is declared; 0 disables the watchdog. The counter is 10 bits.
- clk  in  1  system clock; all logic runs on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sol_leer_0 / sol_leer_1  in  1  read request, level, held until the matching hecho pulse.
- sol_escribir_0 / sol_escribir_1  in  1  write request, level, held until the matching hecho pulse.
- sol_direccion_0 / sol_direccion_1  in  ANCHO_DIR  request address; must be stable while the request is held.
- sol_datos_0 / sol_datos_1  in  ANCHO_DATOS  write data; must be stable while the request is held.
- hecho_0 / hecho_1  out  1  one-cycle completion pulse (success or timeout).
- datos_salida  out  ANCHO_DATOS  last captured read data; valid from a hecho pulse of a read until the next read completes.
- error_tiempo  out  1  sticky flag; set on any timeout, cleared only by reset.
- leer / escribir  out  1  memory command, level.
- direccion_memoria  out  ANCHO_DIR  memory address.
- datos_por_escribir  out  ANCHO_DATOS  memory write data.
- operacion_completada  in  1  completion pulse from the memory controller.
- datos_leidos  in  ANCHO_DATOS  memory read data; valid in the cycle operacion_completada is high.

## Operation
- States:
  - LIBRE: idle.
  - ESPERA: command outstanding.
  - FIN: one-cycle completion, hecho high.
- In LIBRE, any active request triggers a grant. If both requesters are active, the one not served last wins. The last-served register resets to 1, so requester 0 wins the first tie.
- At the grant edge:
  - the address, data and operation are latched into output registers;
  - leer or escribir is driven high;
  - the state moves to ESPERA and the watchdog counter is cleared.
- If a requester asserts both leer and escribir, the write wins. The read is not queued.
- In ESPERA, the command, address and data are held constant and the counter increments each cycle.
  - On operacion_completada=1: the command is dropped, datos_leidos is captured into datos_salida (reads only), and the state moves to FIN.
  - When the counter reaches MAX_ESPERA (MAX_ESPERA≠0) without completion: the command is dropped, error_tiempo is set, and the state moves to FIN. datos_salida is not updated.
  - If completion and the limit occur in the same cycle, completion wins and no error is raised.
- In FIN, hecho_g pulses high and the last-served register is updated to g. The state returns to LIBRE unconditionally. Requests are not examined in FIN.
- operacion_completada is ignored in LIBRE and FIN.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: every output is 0, the state is LIBRE, the counter is 0, and the last-served register is 1. An asserted reset aborts any operation in progress immediately.

## Timing
- A request seen at edge k makes leer/escribir visible after edge k.
- The earliest completion is operacion_completada high in cycle k+1. The command drops after edge k+1, and hecho is high during cycle k+2.
- Back-to-back operations need at least 3 cycles each: grant, ESPERA (≥1), FIN.
- Requesters must drop their request in the cycle hecho is high. A request still high after FIN is treated as a new request.
- With no response, the timeout fires MAX_ESPERA cycles after the grant edge.

## Structure
- Package arbitro_memoria_pkg holds:
  - the state enum (LIBRE, ESPERA, FIN);
  - the default width constants;
  - the operation encoding (OP_LEER, OP_ESCRIBIR).
- There is a single module with no sub-module. The round-robin select is a small combinational function in the package.

## Test plan
- Single read: requester 0 reads 0x00010, memory completes 4 cycles later with datos_leidos=7. Expected: leer high for 5 cycles, hecho_0 one cycle, datos_salida=7, error_tiempo=0.
- Tie: both requesters request at the same edge after reset. Expected: requester 0 is granted first and requester 1 second (write 0x3FFFF, data 0xDEADBEEF_00000001). Both then re-request and requester 0 is granted again.
- Read+write on one requester: requester 1 asserts both. Expected: escribir=1, leer=0 throughout.
- Timeout: MAX_ESPERA=8, no completion. Expected: the command drops 8 cycles after the grant, hecho pulses, error_tiempo=1 and stays 1 through later successful operations until reset.
- Simultaneous completion and limit: completion arrives at cycle 8 with MAX_ESPERA=8. Expected: no error, data captured.
- Reset mid-ESPERA: reset asserted asynchronously between edges. Expected: all outputs go to 0 immediately, and a late operacion_completada after reset produces no hecho.
